addsub_arbiter: RTL and testbench
=================================

// Module: addsub_arbiter
// PURPOSE
//   Shares one combinational 32-bit adder/subtractor (A, B, Select -> Sum, CarryOut)
//   among NUM_REQ requesters. Each request is accepted by round-robin arbitration
//   and its operands are registered onto the shared unit. The result is captured
//   after a fixed settle time and returned on a single valid/ready response channel
//   tagged with the requester ID.
//   Sits between the requesting datapath blocks and the single add/sub instance.
// PARAMETERS
//   NUM_REQ        4    number of requesters, >=2
//   WIDTH          32   operand/result width; must match the shared unit
//   ID_W           2    rsp_id width, = $clog2(NUM_REQ)
//   SETTLE_CYCLES  2    clocks the unit's outputs are allowed to settle, >=1
// PORTS
//   clk         in   1              rising-edge clock
//   rst_n       in   1              asynchronous, active-low reset
//   req_valid   in   NUM_REQ        per-requester request valid
//   req_a       in   NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//   req_b       in   NUM_REQ*WIDTH  operand B; same packing as req_a
//   req_sub     in   NUM_REQ        1 = A-B, 0 = A+B
//   req_ready   out  NUM_REQ        one-hot accept strobe; request taken when valid&ready
//   au_a        out  WIDTH          registered operand A to shared unit
//   au_b        out  WIDTH          registered operand B to shared unit
//   au_select   out  1              registered Select to shared unit
//   au_sum      in   WIDTH          Sum from shared unit
//   au_carry    in   1              CarryOut from shared unit
//   rsp_valid   out  1              response valid
//   rsp_ready   in   1              response consumer ready
//   rsp_id      out  ID_W           index of the requester that owns the response
//   rsp_sum     out  WIDTH          captured result
//   rsp_carry   out  1              captured CarryOut (subtract: 1 = no borrow)
// BEHAVIOUR
// - Reset (async assert, sync deassert at the board level): state=IDLE, rr_ptr=0,
//   cnt=0. All registered outputs are 0: au_*, rsp_valid, rsp_id, rsp_sum,
//   rsp_carry. req_ready is 0.
// - FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: if any req_valid, choose the first set bit at or after rr_ptr (wrapping).
//     req_ready[g]=1 combinationally in this cycle only. At the clock edge:
//     au_a/au_b/au_select <= req_a/b/sub[g], id <= g, rr_ptr <= (g+1)%NUM_REQ,
//     cnt <= SETTLE_CYCLES-1, ->WAIT. With no valid: stay in IDLE, req_ready=0.
//   WAIT: if cnt!=0, decrement cnt. If cnt==0: rsp_sum<=au_sum,
//     rsp_carry<=au_carry, rsp_id<=id, rsp_valid<=1, ->RESP.
//   RESP: hold rsp_* stable. On rsp_valid&rsp_ready: rsp_valid<=0, ->IDLE.
// - req_ready is 0 in WAIT and RESP. There is no grant in the same cycle as a
//   response handshake.
// - Latency: grant in cycle 0 -> rsp_valid first high in cycle SETTLE_CYCLES+1.
// - Minimum issue interval: SETTLE_CYCLES+2 cycles.
// - au_* change only at grant, so the shared unit's inputs stay stable for the
//   whole WAIT period.
// - A requester must hold req_* stable while req_valid=1 and it has not been
//   granted. Dropping req_valid before grant is legal; that request is lost.
// - Arithmetic is modulo 2^WIDTH. Carry semantics are those of the shared unit
//   (subtract = A + ~B + 1).
// - Reset mid-operation: the in-flight transaction is discarded, rsp_valid never
//   rises for it, and rr_ptr returns to 0.
// CONFIGURATION
//   ADDSUB_OVERFLOW_EN defined: adds output rsp_overflow (1 bit), registered
//     together with rsp_sum. It is the signed overflow of the operation:
//     au_a[MSB]==b_eff[MSB] && rsp_sum[MSB]!=au_a[MSB], where b_eff = au_select ? ~au_b : au_b.
//     It resets to 0.
//   Not defined: the port and its logic are absent. All other behaviour is identical.
// TESTING
// - Reset: rst_n=0 mid-run -> all outputs 0 immediately; after release the first
//   grant goes to requester 0.
// - Single op: req0 A=5 B=3 sub=1, SETTLE=2 -> req_ready=0001 in cycle 0;
//   rsp_valid in cycle 3 with id=0, sum=2, carry=1.
// - Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0.
//   Each grant is spaced 4 cycles apart.
// - Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable; req_ready=0 on all
//   requesters. Grant resumes on the cycle after the handshake.
// - Boundaries: 0xFFFFFFFF+1 -> sum=0, carry=1. 0-1 -> 0xFFFFFFFF, carry=0.
//   With ADDSUB_OVERFLOW_EN: 0x7FFFFFFF+1 -> overflow=1; 0x80000000-1 -> overflow=1.
// - Reset in WAIT: assert rst_n low in cycle 1 of an op -> no rsp_valid for that
//   op; au_* return to 0.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter_if
//  Description : Bundle of request, shared-unit and response signals for
//                addsub_arbiter.
//                slave  - the arbiter side (addsub_arbiter uses this modport)
//                master - requesters, shared add/sub unit and response consumer
//  Signals     : req_valid/req_a/req_b/req_sub/req_ready - request channel,
//                operands packed per requester at [i*WIDTH +: WIDTH]
//                au_a/au_b/au_select/au_sum/au_carry     - shared unit link
//                rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_carry - response
//  Config      : ADDSUB_OVERFLOW_EN adds rsp_overflow to the response channel
//  Revision    : 1.0 - initial release
// ============================================================================
interface addsub_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic [NUM_REQ-1:0]       req_ready;

    logic [WIDTH-1:0]         au_a;
    logic [WIDTH-1:0]         au_b;
    logic                     au_select;
    logic [WIDTH-1:0]         au_sum;
    logic                     au_carry;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_carry;

`ifdef ADDSUB_OVERFLOW_EN
    logic                     rsp_overflow;

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output au_a, au_b, au_select,
        input  au_sum, au_carry,
        output rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  au_a, au_b, au_select,
        output au_sum, au_carry,
        input  rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow,
        output rsp_ready
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output au_a, au_b, au_select,
        input  au_sum, au_carry,
        output rsp_valid, rsp_id, rsp_sum, rsp_carry,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  au_a, au_b, au_select,
        output au_sum, au_carry,
        input  rsp_valid, rsp_id, rsp_sum, rsp_carry,
        output rsp_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter
//  Description : Round-robin sharing of one combinational add/sub unit among
//                NUM_REQ requesters. A granted request's operands are
//                registered onto the unit, the result is captured after
//                SETTLE_CYCLES clocks and returned on a valid/ready response
//                channel tagged with the requester index.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - addsub_arbiter_if.slave (request, shared unit and
//                        response channels)
//  Config      : ADDSUB_OVERFLOW_EN adds a registered signed-overflow flag
//                (rsp_overflow) captured together with rsp_sum
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 32,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  id;

    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  slot;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    // Scan starting at rr_ptr and wrapping; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[slot]) begin
                grant_found = 1'b1;
                grant_idx   = slot;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (grant_found)   next_state = S_WAIT;
            S_WAIT:  if (cnt == '0)     next_state = S_RESP;
            S_RESP:  if (bus.rsp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic: the accept strobe exists only while idle and out of reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == S_IDLE && grant_found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

`ifdef ADDSUB_OVERFLOW_EN
    // MSB of the effective B operand the unit adds (inverted for subtract).
    logic b_eff_msb;
    assign b_eff_msb = bus.au_select ^ bus.au_b[WIDTH-1];
`endif

    // Datapath registers. au_* only move at grant so the shared unit sees
    // stable inputs for the whole settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            cnt           <= '0;
            id            <= '0;
            bus.au_a      <= '0;
            bus.au_b      <= '0;
            bus.au_select <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_carry <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
            bus.rsp_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        bus.au_a      <= a_arr[grant_idx];
                        bus.au_b      <= b_arr[grant_idx];
                        bus.au_select <= bus.req_sub[grant_idx];
                        id            <= grant_idx;
                        rr_ptr        <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                        cnt           <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.rsp_sum   <= bus.au_sum;
                        bus.rsp_carry <= bus.au_carry;
                        bus.rsp_id    <= id;
                        bus.rsp_valid <= 1'b1;
`ifdef ADDSUB_OVERFLOW_EN
                        bus.rsp_overflow <= (bus.au_a[WIDTH-1] == b_eff_msb) &&
                                            (bus.au_sum[WIDTH-1] != bus.au_a[WIDTH-1]);
`endif
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_arbiter
//  Description : Self-checking bench for addsub_arbiter. A cycle-based
//                transaction model predicts grants, shared-unit operands and
//                responses every cycle; directed vectors add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;
    localparam int SETTLE  = 2;

    logic clk;
    logic rst_n;

    addsub_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    addsub_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WIDTH        (WIDTH),
        .ID_W         (ID_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Shared combinational add/sub unit: subtract is A + ~B + 1.
    assign {bus.au_carry, bus.au_sum} = {1'b0, bus.au_a}
                                      + {1'b0, (bus.au_select ? ~bus.au_b : bus.au_b)}
                                      + {32'd0, bus.au_select};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          m_busy;
    int          m_gcyc;
    int          m_ptr;
    int          m_id;
    logic [31:0] m_a, m_b;
    logic        m_sub;
    logic        m_rvalid;
    logic [1:0]  m_rid;
    logic [31:0] m_rsum;
    logic        m_rcarry;
    logic        m_rovf;
    logic [63:0] s64;
    longint      sr;
    logic [3:0]  er;
    int          g;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_id = 0; m_gcyc = 0;
            m_a = '0; m_b = '0; m_sub = 1'b0;
            m_rvalid = 1'b0; m_rid = '0; m_rsum = '0; m_rcarry = 1'b0; m_rovf = 1'b0;
            check("rst_req_ready", 64'(bus.req_ready), 64'd0);
            check("rst_au_a",      64'(bus.au_a),      64'd0);
            check("rst_au_b",      64'(bus.au_b),      64'd0);
            check("rst_au_sel",    64'(bus.au_select), 64'd0);
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
            check("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
            check("rst_rsp_carry", 64'(bus.rsp_carry), 64'd0);
`ifdef ADDSUB_OVERFLOW_EN
            check("rst_rsp_ovf",   64'(bus.rsp_overflow), 64'd0);
`endif
        end else begin
            // Result becomes visible SETTLE+1 cycles after the grant cycle.
            if (m_busy && cyc == m_gcyc + SETTLE + 1) begin
                m_rvalid = 1'b1;
                m_rid    = 2'(m_id);
                if (m_sub) begin
                    m_rsum   = m_a - m_b;
                    m_rcarry = (m_a >= m_b);
                    sr       = longint'($signed(m_a)) - longint'($signed(m_b));
                end else begin
                    s64      = {32'd0, m_a} + {32'd0, m_b};
                    m_rsum   = s64[31:0];
                    m_rcarry = s64[32];
                    sr       = longint'($signed(m_a)) + longint'($signed(m_b));
                end
                m_rovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(er));
            check("au_a",      64'(bus.au_a),      64'(m_a));
            check("au_b",      64'(bus.au_b),      64'(m_b));
            check("au_select", 64'(bus.au_select), 64'(m_sub));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rvalid));
            check("rsp_id",    64'(bus.rsp_id),    64'(m_rid));
            check("rsp_sum",   64'(bus.rsp_sum),   64'(m_rsum));
            check("rsp_carry", 64'(bus.rsp_carry), 64'(m_rcarry));
`ifdef ADDSUB_OVERFLOW_EN
            check("rsp_overflow", 64'(bus.rsp_overflow), 64'(m_rovf));
`endif
            if (g >= 0) begin
                m_busy = 1;
                m_gcyc = cyc;
                m_id   = g;
                m_a    = bus.req_a[g*32 +: 32];
                m_b    = bus.req_b[g*32 +: 32];
                m_sub  = bus.req_sub[g];
                m_ptr  = (g + 1) % NUM_REQ;
            end
            if (m_rvalid && bus.rsp_ready) begin
                m_rvalid = 1'b0;
                m_busy   = 0;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] es, input logic ec, input string nm);
        int lat;
        bit seen;
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
        bus.req_sub[r]        = s;
        bus.req_valid         = 4'(1 << r);
        @(negedge clk);
        check({nm, "_grant"}, 64'(bus.req_ready), 64'(1 << r));
        @(posedge clk); #1;
        bus.req_valid = '0;
        lat  = 1;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'd3);
        check({nm, "_id"},      64'(bus.rsp_id),    64'(r));
        check({nm, "_sum"},     64'(bus.rsp_sum),   64'(es));
        check({nm, "_carry"},   64'(bus.rsp_carry), 64'(ec));
        @(posedge clk); #1;
    endtask

    int  gl[$];
    int  gc[$];
    int  lat;
    bit  seen;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = '0;
        bus.rsp_ready = 1'b1;

        // Reset: no accept strobe even with every requester asking.
        @(negedge clk);
        check("reset_ready", 64'(bus.req_ready), 64'd0);
        check("reset_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op: 5 - 3.
        do_op(0, 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, "single");

        // Reset during WAIT: op on requester 1 is discarded.
        bus.req_a[32 +: 32] = 32'h0000_1234;
        bus.req_b[32 +: 32] = 32'h0000_0001;
        bus.req_sub[1]      = 1'b0;
        bus.req_valid       = 4'b0010;
        @(negedge clk);
        check("rstw_grant", 64'(bus.req_ready), 64'h2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("rstw_au_a_loaded", 64'(bus.au_a), 64'h1234);
        rst_n = 1'b0;
        #1;
        check("rstw_au_a_cleared", 64'(bus.au_a), 64'd0);
        check("rstw_au_b_cleared", 64'(bus.au_b), 64'd0);
        @(negedge clk);
        check("rstw_no_rsp", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fairness: all four continuously valid; first grant after reset is 0.
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*32 +: 32] = 32'(100 * (i + 1));
            bus.req_b[i*32 +: 32] = 32'(i + 1);
            bus.req_sub[i]        = i[0];
        end
        bus.req_valid = 4'hF;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                gl.push_back($clog2(bus.req_ready));
                gc.push_back(t);
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        check("fair_count", 64'(gl.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < gl.size()) check($sformatf("fair_order%0d", i), 64'(gl[i]), 64'(i % 4));
            if (i > 0 && i < gc.size()) check($sformatf("fair_gap%0d", i), 64'(gc[i] - gc[i-1]), 64'd4);
        end
        repeat (6) @(posedge clk);
        #1;

        // Backpressure: response held, no grants until the handshake.
        bus.rsp_ready       = 1'b0;
        bus.req_a[32 +: 32] = 32'd10;
        bus.req_b[32 +: 32] = 32'd20;
        bus.req_sub[1]      = 1'b0;
        bus.req_valid       = 4'b0010;
        @(negedge clk);
        check("bp_grant", 64'(bus.req_ready), 64'h2);
        @(posedge clk); #1;
        bus.req_a[64 +: 32] = 32'd7;
        bus.req_b[64 +: 32] = 32'd2;
        bus.req_sub[2]      = 1'b1;
        bus.req_valid       = 4'b0100;
        lat  = 1;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check("bp_latency", 64'(lat), 64'd3);
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_stall_ready", 64'(bus.req_ready), 64'd0);
            check("bp_stall_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_stall_sum",   64'(bus.rsp_sum),   64'd30);
            check("bp_stall_id",    64'(bus.rsp_id),    64'd1);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_hs_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_resume", 64'(bus.req_ready), 64'h4);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        // Boundaries.
        do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, "bnd_add");
        do_op(1, 32'h0000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, "bnd_sub");
`ifdef ADDSUB_OVERFLOW_EN
        check("bnd_sub_ovf", 64'(bus.rsp_overflow), 64'd0);
        do_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, "ovf_add");
        check("ovf_add_flag", 64'(bus.rsp_overflow), 64'd1);
        do_op(3, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, "ovf_sub");
        check("ovf_sub_flag", 64'(bus.rsp_overflow), 64'd1);
`endif
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
